// File: rtl/conv_bias_ram_loader.sv
// Runtime-loadable bias store: a valid/ready byte stream fills DEPTH signed entries,
// which are then served through the same combinational row/col port the bias ROMs use.
//
// state | meaning
// IDLE  | no load since reset; read port returns 0
// LOAD  | accepting beats into mem[wr_ptr]; read port returns 0
// DONE  | all DEPTH entries written; read port serves mem[row]
module conv_bias_ram_loader #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     s_valid,
  input  logic [DATA_W-1:0]        s_data,
  output logic                     s_ready,
  output logic                     busy,
  output logic                     load_done,
  input  logic [IDX_W-1:0]         row,
  input  logic [IDX_W-1:0]         col,
  output logic signed [DATA_W-1:0] data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [IDX_W:0] DEPTH_X = (IDX_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   wr_ptr;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic               accept;
  logic               row_ok;

  assign s_ready = (state == LOAD);
  assign busy    = (state == LOAD);
  assign accept  = s_ready && s_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      load_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= LOAD;
            wr_ptr <= '0;
          end
        end
        LOAD: begin
          // start is deliberately ignored here so a stray pulse cannot restart the pointer
          if (accept) begin
            if (wr_ptr == LAST_PTR) begin
              state     <= DONE;
              wr_ptr    <= '0;
              load_done <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + PTR_W'(1);
            end
          end
        end
        DONE: begin
          if (start) begin
            state     <= LOAD;
            wr_ptr    <= '0;
            load_done <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          wr_ptr    <= '0;
          load_done <= 1'b0;
        end
      endcase
    end
  end

  // Storage is never cleared, so a reset mid-load keeps the partial contents.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem[wr_ptr] <= s_data;
    end
  end

  assign row_ok = ({1'b0, row} < DEPTH_X);

  always_comb begin
    data = '0;
    if (load_done && row_ok && (col == '0)) begin
      data = $signed(mem[row[PTR_W-1:0]]);
    end
  end

endmodule

// File: doc/conv_bias_ram_loader.md
Name: conv_bias_ram_loader

Overview:
- Writable counterpart to the per-layer bias ROMs: accepts a byte stream of signed Q1.7 bias values over a valid/ready handshake and stores them in an internal register array.
- Serves the stored values back through the same combinational row/col read port the conv datapath already uses for bias ROMs, so a layer's biases can be reloaded at runtime instead of being baked in at elaboration.

Parameters:
- DEPTH, 32, number of bias entries (one per output channel); ≥ 2.
- DATA_W, 8, bias word width (signed Q1.7).
- IDX_W, 16, width of row/col read indices.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; begins (re)load from entry 0.
- s_valid  input  1  write-stream beat valid.
- s_data  input  DATA_W  write-stream bias value, signed Q1.7.
- s_ready  output  1  loader accepts a beat this cycle.
- busy  output  1  load in progress.
- load_done  output  1  all DEPTH entries written since last start; read data valid.
- row  input  IDX_W  read index (channel).
- col  input  IDX_W  read column; only 0 is valid.
- data  output  signed DATA_W  combinational read result.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- State machine: IDLE, LOAD, DONE; register wr_ptr holds clog2(DEPTH) bits.
- Reset (rst high at posedge):
  - state goes to IDLE, wr_ptr goes to 0, load_done goes to 0.
  - Array contents are not cleared.
  - After reset, s_ready=0, busy=0, load_done=0, and data reads 0.
- IDLE:
  - s_ready=0, busy=0.
  - start=1 → LOAD, wr_ptr←0.
- LOAD:
  - s_ready=1, busy=1; both decoded combinationally from the registered state.
  - Beat accepted when s_valid && s_ready at a posedge: mem[wr_ptr]←s_data, wr_ptr←wr_ptr+1.
  - Beat at wr_ptr==DEPTH-1 → DONE, wr_ptr←0, load_done←1.
  - s_ready therefore deasserts on the cycle after the final beat; no extra beat can be accepted.
  - s_valid low: hold state, no write.
  - start during LOAD is ignored; pointer is not restarted.
- DONE:
  - s_ready=0, busy=0, load_done=1.
  - start=1 → LOAD, wr_ptr←0, load_done←0 in the same edge; entries are progressively overwritten.
- Read port (purely combinational):
  - data = mem[row] when load_done=1 && row<DEPTH && col==0; otherwise 0.
  - Reads during LOAD return 0, even for already-written entries.
  - No range aliasing: row ≥ DEPTH returns 0, never mem[row mod DEPTH].
- Simultaneous rst and start/s_valid: rst wins; no write occurs.
- Reset mid-load: partial contents are retained, but load_done=0 until a complete new load finishes.
- Data passes bit-exact; no scaling, saturation or sign manipulation.
- Latency:
  - First beat can be accepted the cycle after start.
  - load_done rises the cycle after the DEPTH-th accepted beat.
  - Minimum load is DEPTH+1 cycles from start.

Test Plan:
- Reset, then idle 5 cycles → s_ready=0, busy=0, load_done=0, data=0 for row=0,col=0.
- start, then stream 32 beats back-to-back with mem[5]=60 (0x3C), mem[16]=-55 (0xC9), mem[31]=12 →
  - load_done=1 exactly one cycle after beat 32; s_ready=0 that cycle.
  - row=5 → 60; row=16 → -55 (0xC9); row=31 → 12; row=32 → 0; row=5,col=1 → 0.
- Stream with s_valid toggled randomly (≈50% duty) →
  - Stored values match the stream order exactly.
  - No writes on cycles where s_valid=0.
  - busy=1 throughout the load.
- start pulse at beat 10 of a load → ignored; the load completes after 32 total beats with contents in order.
- Assert rst at beat 20, then start a new full load of all -1 (0xFF) → load_done=0 until the new load completes; then every row<32 reads -1.
- After load_done, hold s_valid=1 with s_data=0x7F for 3 cycles with no start → no writes, contents unchanged, s_ready stays 0.
